char_move_ctrl: RTL and testbench
=================================

Name: char_move_ctrl

Overview:
- Character movement sequencer for the jump game: turns `left_btn` / `right_btn` / `jump_btn` into signed per-tick velocity commands for the physics/position datapath.
- Jump-charge style: jump is charged while held and launched on release.
- Sits between the button inputs and the physics integrator. Collision flags return from the map/obstacle checker.
- State advances only on `phy_tick`.

Parameters:
- SIGNED_PHY_WIDTH, 15, width of signed velocity outputs (PHY_WIDTH+1).
- CHARGE_WIDTH, 5, charge counter width.
- MAX_CHARGE, 31, charge saturation value; must be ≤ 2^CHARGE_WIDTH-1.
- WALK_SPEED, 2, ground walk |vel_x|.
- JUMP_VX, 4, launch |vel_x| when a direction is latched.
- JUMP_VY_BASE, 4, launch vel_y at charge 0.
- JUMP_VY_STEP, 1, added vel_y per charge unit.
- GRAVITY, 1, vel_y decrement per tick in air.
- MAX_FALL, 16, fall speed clamp (vel_y ≥ -MAX_FALL).
- LAND_TICKS, 4, ticks of landing lockout.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset: asynchronous, active-low.
- phy_tick  in  1  one-cycle physics update strobe.
- left_btn  in  1  synchronized, debounced level.
- right_btn  in  1  synchronized, debounced level.
- jump_btn  in  1  synchronized, debounced level.
- on_ground  in  1  character feet on platform/floor.
- hit_wall_x  in  1  horizontal collision this tick.
- hit_ceiling  in  1  head collision this tick.
- vel_x  out  SIGNED_PHY_WIDTH  signed; +right.
- vel_y  out  SIGNED_PHY_WIDTH  signed; +up.
- state  out  3  0 IDLE, 1 WALK, 2 CHARGE, 3 AIR, 4 LAND.
- charge  out  CHARGE_WIDTH  current charge.
- facing  out  1  0 right, 1 left.
- launch  out  1  one-cycle pulse on jump launch.

Behaviour:
- Reset (async, any time, including mid-charge or mid-air): state=IDLE; vel_x=0, vel_y=0, charge=0, facing=0, launch=0; internal dir and land counter cleared.
- All registers update only on a `sys_clk` edge where `phy_tick`=1. Inputs are sampled that cycle and outputs are valid the next cycle (1-cycle latency). Outputs hold between ticks.
- `launch` is high only the cycle after the launching tick, otherwise 0.
- Walk input: exactly one of left/right pressed. Both pressed or neither = no walk.
- IDLE / WALK (checked in priority order):
  - !on_ground → AIR, vel_y unchanged (0).
  - jump_btn → CHARGE, charge=0, vel_x=0.
  - walk input → WALK, vel_x=±WALK_SPEED, facing updated.
  - else → IDLE, vel_x=0.
- CHARGE: vel_x=0, vel_y=0.
  - Each tick, latch dir: right only=+1, left only=-1, else 0. facing follows a nonzero dir.
  - !on_ground → AIR, charge=0, no launch.
  - jump_btn released, or charge==MAX_CHARGE at tick entry (auto-launch) → AIR, launch=1:
    - vel_y = JUMP_VY_BASE + charge*JUMP_VY_STEP
    - vel_x = dir*JUMP_VX
    - charge=0
  - else charge += 1, saturating at MAX_CHARGE.
- AIR: buttons ignored.
  - vel_y ← max(vel_y − GRAVITY, −MAX_FALL).
  - hit_wall_x → vel_x ← −vel_x; facing toggles if vel_x≠0.
  - hit_ceiling with vel_y>0 → vel_y ← 0. Gravity is not applied that tick.
  - Wall and ceiling on the same tick: both apply.
  - on_ground with vel_y ≤ 0 (pre-update value) → LAND, vel_x=0, vel_y=0, land counter=LAND_TICKS−1. This takes priority over wall/ceiling.
  - on_ground with vel_y>0 is ignored (rising through a platform edge).
- LAND: buttons ignored; vel=0.
  - !on_ground → AIR.
  - counter==0 → IDLE.
  - else counter −= 1.
  - Total dwell is LAND_TICKS ticks.
- Arithmetic: signed, width SIGNED_PHY_WIDTH. Launch product is computed at full width; no wrap at defaults.

Test Plan:
- Reset, on_ground=1, right_btn held 3 ticks → WALK, vel_x=+2, facing=0. Release → IDLE, vel_x=0 next tick.
- IDLE, jump_btn held: 1 tick to enter CHARGE, then 10 more ticks (charge=10). Release with right_btn=1, on_ground=0 afterward → launch pulse, AIR, vel_x=+4, vel_y=14. After 3 more ticks vel_y=11.
- jump_btn held 40 ticks → charge saturates at 31. Auto-launch vel_y=35, vel_x=0 (no direction). Then 60 ticks in air → vel_y clamps at −16 and stays.
- AIR vel_x=+4, vel_y=5; one tick with hit_wall_x=1 and hit_ceiling=1 → vel_x=−4, vel_y=0, facing=1.
- AIR vel_y=−3, on_ground=1 with jump_btn held → LAND for 4 ticks with vel 0, then IDLE. Next tick enters CHARGE, charge=0.
- Assert sys_rst_n low mid-CHARGE (charge=7) between ticks → all outputs 0 / IDLE immediately, without waiting for `sys_clk`.

Source files
------------

// File: rtl/char_move_ctrl.sv
// Purpose: jump-game movement sequencer; buttons + collision flags -> signed velocity commands.
// Latency: inputs sampled on a phy_tick clock edge, outputs valid the following cycle.
// Backpressure: none; state moves only on phy_tick and outputs hold between ticks.
module char_move_ctrl #(
    parameter int SIGNED_PHY_WIDTH = 15,
    parameter int CHARGE_WIDTH     = 5,
    parameter int MAX_CHARGE       = 31,
    parameter int WALK_SPEED       = 2,
    parameter int JUMP_VX          = 4,
    parameter int JUMP_VY_BASE     = 4,
    parameter int JUMP_VY_STEP     = 1,
    parameter int GRAVITY          = 1,
    parameter int MAX_FALL         = 16,
    parameter int LAND_TICKS       = 4
) (
    input  logic                               sys_clk,
    input  logic                               sys_rst_n,
    input  logic                               phy_tick,
    input  logic                               left_btn,
    input  logic                               right_btn,
    input  logic                               jump_btn,
    input  logic                               on_ground,
    input  logic                               hit_wall_x,
    input  logic                               hit_ceiling,
    output logic signed [SIGNED_PHY_WIDTH-1:0] vel_x,
    output logic signed [SIGNED_PHY_WIDTH-1:0] vel_y,
    output logic [2:0]                         state,
    output logic [CHARGE_WIDTH-1:0]            charge,
    output logic                               facing,
    output logic                               launch
);

    localparam int SW = SIGNED_PHY_WIDTH;
    localparam int LW = (LAND_TICKS > 2) ? $clog2(LAND_TICKS) : 1;

    localparam logic signed [SW-1:0] WALK_V    = SW'(WALK_SPEED);
    localparam logic signed [SW-1:0] JUMP_VX_V = SW'(JUMP_VX);
    localparam logic signed [SW-1:0] VY_BASE_V = SW'(JUMP_VY_BASE);
    localparam logic signed [SW-1:0] VY_STEP_V = SW'(JUMP_VY_STEP);
    localparam logic signed [SW-1:0] GRAV_V    = SW'(GRAVITY);
    localparam logic signed [SW-1:0] FALL_V    = SW'(MAX_FALL);
    localparam logic [CHARGE_WIDTH-1:0] MAX_C  = CHARGE_WIDTH'(MAX_CHARGE);
    localparam logic [LW-1:0] LAND_INIT        = LW'(LAND_TICKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WALK   = 3'd1,
        ST_CHARGE = 3'd2,
        ST_AIR    = 3'd3,
        ST_LAND   = 3'd4
    } state_t;

    state_t                   state_q;
    logic signed [SW-1:0]     vel_x_q, vel_y_q;
    logic [CHARGE_WIDTH-1:0]  charge_q;
    logic                     facing_q;
    logic                     launch_q;
    logic [LW-1:0]            land_cnt_q;

    logic                     walk_r, walk_l;
    logic signed [SW-1:0]     vy_grav_d, vy_fall_d, launch_vy_d, launch_vx_d;
    logic [CHARGE_WIDTH-1:0]  charge_inc_d;

    // Walk/launch direction decode plus the gravity, launch and charge arithmetic.
    // The direction sampled on the launching tick feeds vel_x directly, so it
    // needs no storage of its own; facing keeps the last nonzero direction.
    always_comb begin
        walk_r       = right_btn & ~left_btn;
        walk_l       = left_btn & ~right_btn;
        vy_grav_d    = vel_y_q - GRAV_V;
        vy_fall_d    = (vy_grav_d < -FALL_V) ? -FALL_V : vy_grav_d;
        launch_vy_d  = VY_BASE_V
                     + $signed({{(SW-CHARGE_WIDTH){1'b0}}, charge_q}) * VY_STEP_V;
        launch_vx_d  = walk_r ? JUMP_VX_V : (walk_l ? -JUMP_VX_V : '0);
        charge_inc_d = (charge_q == MAX_C) ? MAX_C : charge_q + 1'b1;
    end

    // Movement FSM with registered outputs; launch self-clears on the next clock.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            vel_x_q    <= '0;
            vel_y_q    <= '0;
            charge_q   <= '0;
            facing_q   <= 1'b0;
            launch_q   <= 1'b0;
            land_cnt_q <= '0;
        end else begin
            launch_q <= 1'b0;
            if (phy_tick) begin
                case (state_q)
                    ST_IDLE, ST_WALK: begin
                        if (!on_ground) begin
                            state_q <= ST_AIR;
                        end else if (jump_btn) begin
                            state_q  <= ST_CHARGE;
                            charge_q <= '0;
                            vel_x_q  <= '0;
                        end else if (walk_r) begin
                            state_q  <= ST_WALK;
                            vel_x_q  <= WALK_V;
                            facing_q <= 1'b0;
                        end else if (walk_l) begin
                            state_q  <= ST_WALK;
                            vel_x_q  <= -WALK_V;
                            facing_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            vel_x_q <= '0;
                        end
                    end
                    ST_CHARGE: begin
                        vel_x_q <= '0;
                        vel_y_q <= '0;
                        if (walk_r || walk_l) facing_q <= walk_l;
                        if (!on_ground) begin
                            state_q  <= ST_AIR;
                            charge_q <= '0;
                        end else if (!jump_btn || charge_q == MAX_C) begin
                            state_q  <= ST_AIR;
                            launch_q <= 1'b1;
                            vel_y_q  <= launch_vy_d;
                            vel_x_q  <= launch_vx_d;
                            charge_q <= '0;
                        end else begin
                            charge_q <= charge_inc_d;
                        end
                    end
                    ST_AIR: begin
                        // Landing uses the pre-update vel_y and overrides collisions.
                        if (on_ground && vel_y_q <= 0) begin
                            state_q    <= ST_LAND;
                            vel_x_q    <= '0;
                            vel_y_q    <= '0;
                            land_cnt_q <= LAND_INIT;
                        end else begin
                            if (hit_wall_x) begin
                                vel_x_q <= -vel_x_q;
                                if (vel_x_q != 0) facing_q <= ~facing_q;
                            end
                            if (hit_ceiling && vel_y_q > 0) vel_y_q <= '0;
                            else                            vel_y_q <= vy_fall_d;
                        end
                    end
                    ST_LAND: begin
                        vel_x_q <= '0;
                        vel_y_q <= '0;
                        if (!on_ground)           state_q    <= ST_AIR;
                        else if (land_cnt_q == 0) state_q    <= ST_IDLE;
                        else                      land_cnt_q <= land_cnt_q - 1'b1;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign vel_x  = vel_x_q;
    assign vel_y  = vel_y_q;
    assign state  = state_q;
    assign charge = charge_q;
    assign facing = facing_q;
    assign launch = launch_q;

endmodule

// File: tb/tb_char_move_ctrl.sv
module tb_char_move_ctrl;

    logic sys_clk = 1'b0;
    logic sys_rst_n, phy_tick, left_btn, right_btn, jump_btn;
    logic on_ground, hit_wall_x, hit_ceiling;
    logic signed [14:0] vel_x, vel_y;
    logic [2:0] state;
    logic [4:0] charge;
    logic facing, launch;

    int total = 0;
    int bad   = 0;

    char_move_ctrl dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .phy_tick(phy_tick),
        .left_btn(left_btn), .right_btn(right_btn), .jump_btn(jump_btn),
        .on_ground(on_ground), .hit_wall_x(hit_wall_x), .hit_ceiling(hit_ceiling),
        .vel_x(vel_x), .vel_y(vel_y), .state(state), .charge(charge),
        .facing(facing), .launch(launch)
    );

    always #5 sys_clk = ~sys_clk;

    // One physics tick: strobe across one rising edge, return at the next falling edge.
    task automatic tick();
        phy_tick = 1'b1;
        @(posedge sys_clk);
        #1 phy_tick = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic nop(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic apply_reset();
        sys_rst_n = 1'b0; phy_tick = 0; left_btn = 0; right_btn = 0; jump_btn = 0;
        on_ground = 1; hit_wall_x = 0; hit_ceiling = 0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0; phy_tick = 0; left_btn = 0; right_btn = 0; jump_btn = 0;
        on_ground = 1; hit_wall_x = 0; hit_ceiling = 0;
        #23;
        total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
        total++; if (vel_x !== 15'sd0 || vel_y !== 15'sd0) begin bad++; $display("FAIL reset_vel got=%0d,%0d exp=0,0", vel_x, vel_y); end
        total++; if (charge !== 5'd0 || facing !== 1'b0 || launch !== 1'b0) begin bad++; $display("FAIL reset_misc got=%0d,%0b,%0b exp=0,0,0", charge, facing, launch); end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_walk();
        apply_reset();
        right_btn = 1;
        repeat (3) tick();
        total++; if (state !== 3'd1 || vel_x !== 15'sd2 || facing !== 1'b0) begin bad++; $display("FAIL walk_right got=%0d,%0d,%0b exp=1,2,0", state, vel_x, facing); end
        right_btn = 0;
        nop(3);
        total++; if (state !== 3'd1 || vel_x !== 15'sd2) begin bad++; $display("FAIL walk_hold got=%0d,%0d exp=1,2", state, vel_x); end
        tick();
        total++; if (state !== 3'd0 || vel_x !== 15'sd0) begin bad++; $display("FAIL walk_release got=%0d,%0d exp=0,0", state, vel_x); end
        left_btn = 1;
        tick();
        total++; if (state !== 3'd1 || vel_x !== -15'sd2 || facing !== 1'b1) begin bad++; $display("FAIL walk_left got=%0d,%0d,%0b exp=1,-2,1", state, vel_x, facing); end
        right_btn = 1;
        tick();
        total++; if (state !== 3'd0 || vel_x !== 15'sd0 || facing !== 1'b1) begin bad++; $display("FAIL walk_both got=%0d,%0d,%0b exp=0,0,1", state, vel_x, facing); end
    endtask

    task automatic test_charge_launch();
        apply_reset();
        jump_btn = 1;
        tick();
        total++; if (state !== 3'd2 || charge !== 5'd0) begin bad++; $display("FAIL chg_enter got=%0d,%0d exp=2,0", state, charge); end
        repeat (10) tick();
        total++; if (state !== 3'd2 || charge !== 5'd10 || vel_x !== 15'sd0) begin bad++; $display("FAIL chg_count got=%0d,%0d,%0d exp=2,10,0", state, charge, vel_x); end
        jump_btn = 0; right_btn = 1;
        tick();
        total++; if (launch !== 1'b1 || state !== 3'd3) begin bad++; $display("FAIL chg_launch got=%0b,%0d exp=1,3", launch, state); end
        total++; if (vel_x !== 15'sd4 || vel_y !== 15'sd14 || charge !== 5'd0) begin bad++; $display("FAIL chg_launch_vel got=%0d,%0d,%0d exp=4,14,0", vel_x, vel_y, charge); end
        nop(1);
        total++; if (launch !== 1'b0) begin bad++; $display("FAIL chg_launch_pulse got=%0b exp=0", launch); end
        on_ground = 0; right_btn = 0;
        repeat (3) tick();
        total++; if (vel_y !== 15'sd11 || vel_x !== 15'sd4 || state !== 3'd3) begin bad++; $display("FAIL air_gravity got=%0d,%0d,%0d exp=11,4,3", vel_y, vel_x, state); end
        on_ground = 1;
        tick();
        total++; if (state !== 3'd3 || vel_y !== 15'sd10) begin bad++; $display("FAIL air_rising_ground got=%0d,%0d exp=3,10", state, vel_y); end
    endtask

    task automatic test_saturate_fall();
        apply_reset();
        jump_btn = 1;
        repeat (32) tick();
        total++; if (state !== 3'd2 || charge !== 5'd31) begin bad++; $display("FAIL sat_charge got=%0d,%0d exp=2,31", state, charge); end
        tick();
        total++; if (launch !== 1'b1 || vel_y !== 15'sd35 || vel_x !== 15'sd0 || state !== 3'd3) begin bad++; $display("FAIL sat_autolaunch got=%0b,%0d,%0d,%0d exp=1,35,0,3", launch, vel_y, vel_x, state); end
        on_ground = 0;
        repeat (50) tick();
        total++; if (vel_y !== -15'sd15) begin bad++; $display("FAIL fall_pre_clamp got=%0d exp=-15", vel_y); end
        tick();
        total++; if (vel_y !== -15'sd16) begin bad++; $display("FAIL fall_clamp got=%0d exp=-16", vel_y); end
        repeat (9) tick();
        total++; if (vel_y !== -15'sd16 || state !== 3'd3) begin bad++; $display("FAIL fall_clamp_hold got=%0d,%0d exp=-16,3", vel_y, state); end
    endtask

    task automatic test_wall_ceiling();
        apply_reset();
        jump_btn = 1;
        tick();
        tick();
        jump_btn = 0; right_btn = 1;
        tick();
        total++; if (vel_x !== 15'sd4 || vel_y !== 15'sd5) begin bad++; $display("FAIL wc_launch got=%0d,%0d exp=4,5", vel_x, vel_y); end
        on_ground = 0; right_btn = 0; hit_wall_x = 1; hit_ceiling = 1;
        tick();
        total++; if (vel_x !== -15'sd4 || vel_y !== 15'sd0 || facing !== 1'b1) begin bad++; $display("FAIL wc_both got=%0d,%0d,%0b exp=-4,0,1", vel_x, vel_y, facing); end
        hit_wall_x = 0;
        tick();
        total++; if (vel_y !== -15'sd1 || vel_x !== -15'sd4) begin bad++; $display("FAIL wc_ceiling_falling got=%0d,%0d exp=-1,-4", vel_y, vel_x); end
        hit_ceiling = 0;
    endtask

    task automatic test_land();
        apply_reset();
        jump_btn = 1;
        tick();
        jump_btn = 0; right_btn = 1;
        tick();
        total++; if (vel_y !== 15'sd4 || vel_x !== 15'sd4) begin bad++; $display("FAIL land_launch got=%0d,%0d exp=4,4", vel_y, vel_x); end
        on_ground = 0; right_btn = 0;
        repeat (7) tick();
        total++; if (vel_y !== -15'sd3 || facing !== 1'b0) begin bad++; $display("FAIL land_pre got=%0d,%0b exp=-3,0", vel_y, facing); end
        on_ground = 1; jump_btn = 1; hit_wall_x = 1;
        tick();
        hit_wall_x = 0;
        total++; if (state !== 3'd4 || vel_x !== 15'sd0 || vel_y !== 15'sd0 || facing !== 1'b0) begin bad++; $display("FAIL land_enter got=%0d,%0d,%0d,%0b exp=4,0,0,0", state, vel_x, vel_y, facing); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (state !== 3'd4) begin bad++; $display("FAIL land_dwell_%0d got=%0d exp=4", i, state); end
        end
        tick();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL land_exit got=%0d exp=0", state); end
        tick();
        total++; if (state !== 3'd2 || charge !== 5'd0) begin bad++; $display("FAIL land_recharge got=%0d,%0d exp=2,0", state, charge); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        jump_btn = 1;
        tick();
        left_btn = 1;
        repeat (7) tick();
        total++; if (charge !== 5'd7 || facing !== 1'b1) begin bad++; $display("FAIL ar_pre got=%0d,%0b exp=7,1", charge, facing); end
        #2 sys_rst_n = 1'b0;
        #1;
        total++; if (state !== 3'd0 || charge !== 5'd0 || facing !== 1'b0) begin bad++; $display("FAIL ar_immediate got=%0d,%0d,%0b exp=0,0,0", state, charge, facing); end
        total++; if (vel_x !== 15'sd0 || vel_y !== 15'sd0 || launch !== 1'b0) begin bad++; $display("FAIL ar_vel got=%0d,%0d,%0b exp=0,0,0", vel_x, vel_y, launch); end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        left_btn = 0; jump_btn = 0;
        @(negedge sys_clk);
    endtask

    initial begin
        test_reset();
        test_walk();
        test_charge_launch();
        test_saturate_fall();
        test_wall_ceiling();
        test_land();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
